// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - rv32i decode-and-issue stage with hazard hold and execute handshake
module decode_issue #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_if_valid,
    output logic            o_if_ready,
    input  logic [31:0]     i_if_instr,
    input  logic [XLEN-1:0] i_if_pc,
    output logic [4:0]      o_rs1_raddr,
    output logic [4:0]      o_rs2_raddr,
    input  logic [XLEN-1:0] i_rs1_rdata,
    input  logic [XLEN-1:0] i_rs2_rdata,
    input  logic            i_rs1_hazard,
    input  logic            i_rs2_hazard,
    output logic [4:0]      o_rd_chkaddr,
    input  logic            i_rd_busy,
    output logic            o_rd_hdvalid,
    output logic [4:0]      o_rd_hdaddr,
    output logic            o_ex_valid,
    input  logic            i_ex_ready,
    output logic [XLEN-1:0] o_ex_pc,
    output logic [XLEN-1:0] o_ex_rs1_data,
    output logic [XLEN-1:0] o_ex_rs2_data,
    output logic [XLEN-1:0] o_ex_imm,
    output logic [6:0]      o_ex_opcode,
    output logic [2:0]      o_ex_funct3,
    output logic            o_ex_funct7b5,
    output logic [4:0]      o_ex_rd_addr,
    output logic            o_ex_rd_wen,
    output logic            o_ex_illegal,
    input  logic            i_flush
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [6:0]      opcode;
    logic [4:0]      rs1_field;
    logic [4:0]      rs2_field;
    logic [4:0]      rd_field;
    logic            sign_bit;

    logic            uses_rs1;
    logic            uses_rs2;
    logic            writes_rd;
    logic            illegal;
    logic [XLEN-1:0] imm;

    logic            rs1_used;
    logic            rs2_used;
    logic            rd_wen;
    logic            held_hit;
    logic            stall;
    logic            accept;
    logic            handoff;

    logic            ex_valid_q,    ex_valid_d;
    logic [XLEN-1:0] pc_q,          pc_d;
    logic [XLEN-1:0] rs1_data_q,    rs1_data_d;
    logic [XLEN-1:0] rs2_data_q,    rs2_data_d;
    logic [XLEN-1:0] imm_q,         imm_d;
    logic [6:0]      opcode_q,      opcode_d;
    logic [2:0]      funct3_q,      funct3_d;
    logic            funct7b5_q,    funct7b5_d;
    logic [4:0]      rd_addr_q,     rd_addr_d;
    logic            rd_wen_q,      rd_wen_d;
    logic            illegal_q,     illegal_d;

    assign opcode    = i_if_instr[6:0];
    assign rs1_field = i_if_instr[19:15];
    assign rs2_field = i_if_instr[24:20];
    assign rd_field  = i_if_instr[11:7];
    assign sign_bit  = i_if_instr[31];

    assign o_rs1_raddr  = rs1_field;
    assign o_rs2_raddr  = rs2_field;
    assign o_rd_chkaddr = rd_field;

    // Opcode decode: operand usage, immediate format and legality
    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        illegal   = 1'b0;
        imm       = '0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                writes_rd = 1'b1;
                imm       = {{(XLEN-31){sign_bit}}, i_if_instr[30:12], 12'b0};
            end
            OP_JAL: begin
                writes_rd = 1'b1;
                imm       = {{(XLEN-20){sign_bit}}, i_if_instr[19:12], i_if_instr[20],
                             i_if_instr[30:21], 1'b0};
            end
            OP_JALR, OP_LOAD, OP_OPIMM: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                imm       = {{(XLEN-11){sign_bit}}, i_if_instr[30:20]};
            end
            OP_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm      = {{(XLEN-12){sign_bit}}, i_if_instr[7], i_if_instr[30:25],
                            i_if_instr[11:8], 1'b0};
            end
            OP_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm      = {{(XLEN-11){sign_bit}}, i_if_instr[30:25], i_if_instr[11:7]};
            end
            OP_OP: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            OP_MISC, OP_SYSTEM: begin
                writes_rd = 1'b0;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // Hazard check: hold while a used source or the destination has a pending writer
    always_comb begin
        rs1_used = uses_rs1 && (rs1_field != 5'd0);
        rs2_used = uses_rs2 && (rs2_field != 5'd0);
        rd_wen   = writes_rd && (rd_field != 5'd0);
        // The held bundle has not claimed rd yet, so compare against it directly
        held_hit = ex_valid_q && rd_wen_q &&
                   ((rs1_used && (rd_addr_q == rs1_field)) ||
                    (rs2_used && (rd_addr_q == rs2_field)) ||
                    (rd_wen   && (rd_addr_q == rd_field)));
        stall    = i_if_valid &&
                   ((rs1_used && i_rs1_hazard) ||
                    (rs2_used && i_rs2_hazard) ||
                    (rd_wen && i_rd_busy) ||
                    held_hit);
        o_if_ready   = !i_flush && !stall && (!ex_valid_q || i_ex_ready);
        accept       = i_if_valid && o_if_ready;
        handoff      = ex_valid_q && i_ex_ready && !i_flush;
        o_rd_hdvalid = handoff && rd_wen_q;
        o_rd_hdaddr  = rd_addr_q;
    end

    // Next state of the execute bundle: load on accept, drop on handoff or flush
    always_comb begin
        ex_valid_d = ex_valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        opcode_d   = opcode_q;
        funct3_d   = funct3_q;
        funct7b5_d = funct7b5_q;
        rd_addr_d  = rd_addr_q;
        rd_wen_d   = rd_wen_q;
        illegal_d  = illegal_q;
        if (i_flush) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d = 1'b1;
            pc_d       = i_if_pc;
            rs1_data_d = rs1_used ? i_rs1_rdata : '0;
            rs2_data_d = rs2_used ? i_rs2_rdata : '0;
            imm_d      = imm;
            opcode_d   = opcode;
            funct3_d   = i_if_instr[14:12];
            funct7b5_d = i_if_instr[30];
            rd_addr_d  = writes_rd ? rd_field : 5'd0;
            rd_wen_d   = rd_wen;
            illegal_d  = illegal;
        end else if (handoff) begin
            ex_valid_d = 1'b0;
        end
    end

    // Bundle registers with asynchronous reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_valid_q <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            opcode_q   <= '0;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
            rd_addr_q  <= '0;
            rd_wen_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            opcode_q   <= opcode_d;
            funct3_q   <= funct3_d;
            funct7b5_q <= funct7b5_d;
            rd_addr_q  <= rd_addr_d;
            rd_wen_q   <= rd_wen_d;
            illegal_q  <= illegal_d;
        end
    end

    assign o_ex_valid    = ex_valid_q;
    assign o_ex_pc       = pc_q;
    assign o_ex_rs1_data = rs1_data_q;
    assign o_ex_rs2_data = rs2_data_q;
    assign o_ex_imm      = imm_q;
    assign o_ex_opcode   = opcode_q;
    assign o_ex_funct3   = funct3_q;
    assign o_ex_funct7b5 = funct7b5_q;
    assign o_ex_rd_addr  = rd_addr_q;
    assign o_ex_rd_wen   = rd_wen_q;
    assign o_ex_illegal  = illegal_q;

endmodule

// File: tb/tb_decode_issue.sv
// tb/tb_decode_issue.sv - self-checking bench for decode_issue
module tb_decode_issue;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        i_if_valid;
    logic        o_if_ready;
    logic [31:0] i_if_instr;
    logic [31:0] i_if_pc;
    logic [4:0]  o_rs1_raddr, o_rs2_raddr;
    logic [31:0] i_rs1_rdata, i_rs2_rdata;
    logic        i_rs1_hazard, i_rs2_hazard;
    logic [4:0]  o_rd_chkaddr;
    logic        i_rd_busy;
    logic        o_rd_hdvalid;
    logic [4:0]  o_rd_hdaddr;
    logic        o_ex_valid;
    logic        i_ex_ready;
    logic [31:0] o_ex_pc, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm;
    logic [6:0]  o_ex_opcode;
    logic [2:0]  o_ex_funct3;
    logic        o_ex_funct7b5;
    logic [4:0]  o_ex_rd_addr;
    logic        o_ex_rd_wen;
    logic        o_ex_illegal;
    logic        i_flush;

    decode_issue #(.XLEN(32)) dut (
        .clk(clk), .rstn(rstn),
        .i_if_valid(i_if_valid), .o_if_ready(o_if_ready),
        .i_if_instr(i_if_instr), .i_if_pc(i_if_pc),
        .o_rs1_raddr(o_rs1_raddr), .o_rs2_raddr(o_rs2_raddr),
        .i_rs1_rdata(i_rs1_rdata), .i_rs2_rdata(i_rs2_rdata),
        .i_rs1_hazard(i_rs1_hazard), .i_rs2_hazard(i_rs2_hazard),
        .o_rd_chkaddr(o_rd_chkaddr), .i_rd_busy(i_rd_busy),
        .o_rd_hdvalid(o_rd_hdvalid), .o_rd_hdaddr(o_rd_hdaddr),
        .o_ex_valid(o_ex_valid), .i_ex_ready(i_ex_ready),
        .o_ex_pc(o_ex_pc), .o_ex_rs1_data(o_ex_rs1_data),
        .o_ex_rs2_data(o_ex_rs2_data), .o_ex_imm(o_ex_imm),
        .o_ex_opcode(o_ex_opcode), .o_ex_funct3(o_ex_funct3),
        .o_ex_funct7b5(o_ex_funct7b5), .o_ex_rd_addr(o_ex_rd_addr),
        .o_ex_rd_wen(o_ex_rd_wen), .o_ex_illegal(o_ex_illegal),
        .i_flush(i_flush)
    );

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] RD1 = 32'hAAAA0001;
    localparam logic [31:0] RD2 = 32'h55550002;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        wen;
        logic        ill;
        logic [4:0]  rd;
        logic [31:0] r1;
        logic [31:0] r2;
    } vec_t;

    typedef struct {
        logic        r1;
        logic        r2;
        logic        wr;
        logic        ill;
        logic [31:0] imm;
    } dec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] r1d;
        logic [31:0] r2d;
        logic [31:0] imm;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } bundle_t;

    vec_t    vt [10];
    logic [6:0] ops [11];
    bundle_t mb;
    logic    mv;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decoder from the ISA field layouts, using arithmetic on the word
    function automatic dec_t mdec(input logic [31:0] x);
        dec_t d;
        logic [31:0] s;
        s = {32{x[31]}};
        d = '{r1: 1'b0, r2: 1'b0, wr: 1'b0, ill: 1'b0, imm: 32'd0};
        case (x[6:0])
            7'h37, 7'h17: begin d.wr = 1; d.imm = x & 32'hFFFFF000; end
            7'h6F: begin
                d.wr  = 1;
                d.imm = (s << 20) | (32'(x[19:12]) << 12) | (32'(x[20]) << 11) | (32'(x[30:21]) << 1);
            end
            7'h67, 7'h03, 7'h13: begin
                d.r1 = 1; d.wr = 1;
                d.imm = (s << 11) | 32'(x[30:20]);
            end
            7'h63: begin
                d.r1 = 1; d.r2 = 1;
                d.imm = (s << 12) | (32'(x[7]) << 11) | (32'(x[30:25]) << 5) | (32'(x[11:8]) << 1);
            end
            7'h23: begin
                d.r1 = 1; d.r2 = 1;
                d.imm = (s << 11) | (32'(x[30:25]) << 5) | 32'(x[11:7]);
            end
            7'h33: begin d.r1 = 1; d.r2 = 1; d.wr = 1; end
            7'h0F, 7'h73: ;
            default: d.ill = 1;
        endcase
        return d;
    endfunction

    task automatic idle();
        i_if_valid = 0; i_if_instr = 32'h0; i_if_pc = 32'h0;
        i_rs1_rdata = RD1; i_rs2_rdata = RD2;
        i_rs1_hazard = 0; i_rs2_hazard = 0; i_rd_busy = 0;
        i_ex_ready = 1; i_flush = 0;
    endtask

    initial begin
        dec_t d;
        logic u1, u2, wen, held1, held2, heldd, stall, e_ready, hand;
        logic [31:0] ins;

        vt[0] = '{32'h00500093, 32'h100, 32'h00000005, 1'b1, 1'b0, 5'd1, 32'h0, 32'h0};
        vt[1] = '{32'hFE000EE3, 32'h104, 32'hFFFFFFFC, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0};
        vt[2] = '{32'hFFFFFFFF, 32'h108, 32'h00000000, 1'b0, 1'b1, 5'd0, 32'h0, 32'h0};
        vt[3] = '{32'h00000000, 32'h10C, 32'h00000000, 1'b0, 1'b1, 5'd0, 32'h0, 32'h0};
        vt[4] = '{32'h002081B3, 32'h110, 32'h00000000, 1'b1, 1'b0, 5'd3, RD1,   RD2};
        vt[5] = '{32'h123452B7, 32'h114, 32'h12345000, 1'b1, 1'b0, 5'd5, 32'h0, 32'h0};
        vt[6] = '{32'hFE20AC23, 32'h118, 32'hFFFFFFF8, 1'b0, 1'b0, 5'd0, RD1,   RD2};
        vt[7] = '{32'h001000EF, 32'h11C, 32'h00000800, 1'b1, 1'b0, 5'd1, 32'h0, 32'h0};
        vt[8] = '{32'h00000073, 32'h120, 32'h00000000, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0};
        vt[9] = '{32'h00000013, 32'h124, 32'h00000000, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0};
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h63, 7'h23, 7'h33, 7'h0F, 7'h73};

        // Reset state
        rstn = 0;
        idle();
        repeat (3) @(negedge clk);
        chk("rst_ex_valid", 32'(o_ex_valid), 32'd0);
        chk("rst_ex_imm", o_ex_imm, 32'd0);
        chk("rst_ex_pc", o_ex_pc, 32'd0);
        chk("rst_rd_wen", 32'(o_ex_rd_wen), 32'd0);
        chk("rst_hdvalid", 32'(o_rd_hdvalid), 32'd0);
        rstn = 1;
        #1 chk("rst_if_ready", 32'(o_if_ready), 32'd1);

        // Table-driven single-instruction decode
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            i_if_valid = 1; i_if_instr = vt[k].instr; i_if_pc = vt[k].pc;
            #1;
            chk("tbl_if_ready", 32'(o_if_ready), 32'd1);
            chk("tbl_rs1_raddr", 32'(o_rs1_raddr), 32'(vt[k].instr[19:15]));
            chk("tbl_chkaddr", 32'(o_rd_chkaddr), 32'(vt[k].instr[11:7]));
            @(negedge clk);
            i_if_valid = 0;
            #1;
            chk("tbl_ex_valid", 32'(o_ex_valid), 32'd1);
            chk("tbl_pc", o_ex_pc, vt[k].pc);
            chk("tbl_imm", o_ex_imm, vt[k].imm);
            chk("tbl_rd_wen", 32'(o_ex_rd_wen), 32'(vt[k].wen));
            chk("tbl_illegal", 32'(o_ex_illegal), 32'(vt[k].ill));
            chk("tbl_rs1_data", o_ex_rs1_data, vt[k].r1);
            chk("tbl_rs2_data", o_ex_rs2_data, vt[k].r2);
            chk("tbl_opcode", 32'(o_ex_opcode), 32'(vt[k].instr[6:0]));
            chk("tbl_hdvalid", 32'(o_rd_hdvalid), 32'(vt[k].wen));
            if (vt[k].wen) chk("tbl_rd_addr", 32'(o_ex_rd_addr), 32'(vt[k].rd));
        end
        @(negedge clk);

        // Asynchronous reset mid-stream
        i_if_valid = 1; i_if_instr = 32'h00500093; i_ex_ready = 0;
        @(negedge clk);
        i_if_valid = 0; i_ex_ready = 1;
        #1 chk("arst_pre_hdvalid", 32'(o_rd_hdvalid), 32'd1);
        rstn = 0;
        #1;
        chk("arst_ex_valid", 32'(o_ex_valid), 32'd0);
        chk("arst_imm", o_ex_imm, 32'd0);
        chk("arst_hdvalid", 32'(o_rd_hdvalid), 32'd0);
        @(negedge clk);
        rstn = 1;
        #1 chk("arst_if_ready", 32'(o_if_ready), 32'd1);

        // RAW on held instruction, then on hazard map, then release
        @(negedge clk);
        i_if_valid = 1; i_if_instr = 32'h00500093; i_if_pc = 32'h200;
        #1 chk("raw_first_ready", 32'(o_if_ready), 32'd1);
        @(negedge clk);
        i_if_instr = 32'h00108133; i_if_pc = 32'h204;
        #1;
        chk("raw_held_ready", 32'(o_if_ready), 32'd0);
        chk("raw_claim", 32'(o_rd_hdvalid), 32'd1);
        chk("raw_claim_addr", 32'(o_rd_hdaddr), 32'd1);
        @(negedge clk);
        i_rs1_hazard = 1; i_rs2_hazard = 1;
        #1;
        chk("raw_ex_empty", 32'(o_ex_valid), 32'd0);
        chk("raw_haz_ready", 32'(o_if_ready), 32'd0);
        @(negedge clk);
        #1 chk("raw_haz_ready2", 32'(o_if_ready), 32'd0);
        @(negedge clk);
        i_rs1_hazard = 0; i_rs2_hazard = 0; i_rs1_rdata = 32'd5; i_rs2_rdata = 32'd5;
        #1 chk("raw_release_ready", 32'(o_if_ready), 32'd1);
        @(negedge clk);
        i_if_valid = 0;
        #1;
        chk("raw_issue_valid", 32'(o_ex_valid), 32'd1);
        chk("raw_issue_rs1", o_ex_rs1_data, 32'd5);
        chk("raw_issue_rs2", o_ex_rs2_data, 32'd5);
        chk("raw_issue_rd", 32'(o_ex_rd_addr), 32'd2);
        @(negedge clk);
        idle();

        // Backpressure from execute for three cycles
        i_if_valid = 1; i_if_instr = 32'h00500093; i_ex_ready = 0;
        @(negedge clk);
        i_if_instr = 32'h123452B7;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_valid", 32'(o_ex_valid), 32'd1);
            chk("bp_imm_stable", o_ex_imm, 32'd5);
            chk("bp_ready", 32'(o_if_ready), 32'd0);
            chk("bp_no_claim", 32'(o_rd_hdvalid), 32'd0);
            @(negedge clk);
        end
        i_ex_ready = 1;
        #1;
        chk("bp_claim", 32'(o_rd_hdvalid), 32'd1);
        chk("bp_claim_addr", 32'(o_rd_hdaddr), 32'd1);
        chk("bp_ready_again", 32'(o_if_ready), 32'd1);
        @(negedge clk);
        i_if_valid = 0;
        #1;
        chk("bp_next_valid", 32'(o_ex_valid), 32'd1);
        chk("bp_next_imm", o_ex_imm, 32'h12345000);
        chk("bp_next_rd", 32'(o_ex_rd_addr), 32'd5);

        // Flush while a bundle is held and execute is ready
        @(negedge clk);
        i_if_valid = 1; i_if_instr = 32'h00500093;
        @(negedge clk);
        i_if_instr = 32'h123452B7; i_flush = 1;
        #1;
        chk("fl_no_claim", 32'(o_rd_hdvalid), 32'd0);
        chk("fl_ready", 32'(o_if_ready), 32'd0);
        @(negedge clk);
        i_flush = 0; i_if_valid = 0;
        #1 chk("fl_ex_valid", 32'(o_ex_valid), 32'd0);

        // Randomized traffic against the reference model
        mv = 0;
        mb = '{pc: 0, r1d: 0, r2d: 0, imm: 0, op: 0, rd: 0, wen: 0, ill: 0};
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ins = $urandom();
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            ins[11:7]  = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 11) < 11) ins[6:0] = ops[$urandom_range(0, 10)];
            i_if_instr   = ins;
            i_if_valid   = ($urandom_range(0, 3) != 0);
            i_if_pc      = $urandom();
            i_rs1_rdata  = $urandom();
            i_rs2_rdata  = $urandom();
            i_rs1_hazard = ($urandom_range(0, 4) == 0);
            i_rs2_hazard = ($urandom_range(0, 4) == 0);
            i_rd_busy    = ($urandom_range(0, 4) == 0);
            i_ex_ready   = ($urandom_range(0, 3) != 0);
            i_flush      = ($urandom_range(0, 15) == 0);
            #1;
            d     = mdec(ins);
            u1    = d.r1 && (ins[19:15] != 0);
            u2    = d.r2 && (ins[24:20] != 0);
            wen   = d.wr && (ins[11:7] != 0);
            held1 = mv && mb.wen && (mb.rd == ins[19:15]);
            held2 = mv && mb.wen && (mb.rd == ins[24:20]);
            heldd = mv && mb.wen && (mb.rd == ins[11:7]);
            stall = i_if_valid && ((u1 && (i_rs1_hazard || held1)) ||
                                   (u2 && (i_rs2_hazard || held2)) ||
                                   (wen && (i_rd_busy || heldd)));
            e_ready = !i_flush && !stall && (!mv || i_ex_ready);
            hand    = mv && i_ex_ready && !i_flush;
            chk("rnd_if_ready", 32'(o_if_ready), 32'(e_ready));
            chk("rnd_hdvalid", 32'(o_rd_hdvalid), 32'(hand && mb.wen));
            if (hand && mb.wen) chk("rnd_hdaddr", 32'(o_rd_hdaddr), 32'(mb.rd));
            chk("rnd_ex_valid", 32'(o_ex_valid), 32'(mv));
            if (mv) begin
                chk("rnd_pc", o_ex_pc, mb.pc);
                chk("rnd_imm", o_ex_imm, mb.imm);
                chk("rnd_rs1", o_ex_rs1_data, mb.r1d);
                chk("rnd_rs2", o_ex_rs2_data, mb.r2d);
                chk("rnd_op", 32'(o_ex_opcode), 32'(mb.op));
                chk("rnd_wen", 32'(o_ex_rd_wen), 32'(mb.wen));
                chk("rnd_ill", 32'(o_ex_illegal), 32'(mb.ill));
                if (mb.wen) chk("rnd_rd", 32'(o_ex_rd_addr), 32'(mb.rd));
            end
            if (i_flush) begin
                mv = 0;
            end else if (i_if_valid && e_ready) begin
                mv = 1;
                mb.pc  = i_if_pc;
                mb.r1d = u1 ? i_rs1_rdata : 32'd0;
                mb.r2d = u2 ? i_rs2_rdata : 32'd0;
                mb.imm = d.imm;
                mb.op  = ins[6:0];
                mb.rd  = ins[11:7];
                mb.wen = wen;
                mb.ill = d.ill;
            end else if (hand) begin
                mv = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_issue.md
# decode_issue

Decode-and-issue stage of the rv32i pipeline, sitting between instruction fetch and execute, and the sole client of the register file's read ports and hazard-map claim port. It accepts one instruction per cycle from fetch, decodes operand usage and immediates, reads rs1/rs2, and holds the instruction back while any source or destination register has a pending writer. It then registers a decoded bundle for execute under a valid/ready handshake and claims rd in the hazard map when the bundle is handed off.

## Interface
- XLEN, 32, data/address width
- clk  in  1  clock, all state updates on rising edge
- rstn  in  1  reset: one clock; reset is asynchronous and active-low
- i_if_valid / o_if_ready  in/out  1  fetch handshake
- i_if_instr  in  32  instruction word
- i_if_pc  in  XLEN  instruction address
- o_rs1_raddr / o_rs2_raddr  out  5  register-file read addresses, combinational from i_if_instr[19:15] / [24:20]
- i_rs1_rdata / i_rs2_rdata  in  XLEN  read data, same cycle
- i_rs1_hazard / i_rs2_hazard  in  1  hazard-map bit for the addressed register
- o_rd_chkaddr  out  5  i_if_instr[11:7], for the extra hazard-map lookup
- i_rd_busy  in  1  hazard-map bit for o_rd_chkaddr
- o_rd_hdvalid / o_rd_hdaddr  out  1/5  hazard-map claim
- o_ex_valid / i_ex_ready  out/in  1  execute handshake
- o_ex_pc, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm  out  XLEN  registered payload
- o_ex_opcode  out  7; o_ex_funct3  out  3; o_ex_funct7b5  out  1; o_ex_rd_addr  out  5; o_ex_rd_wen  out  1; o_ex_illegal  out  1
- i_flush  in  1  kill the held instruction and block acceptance this cycle

## Operation
- Decode on i_if_instr (opcode [6:0]; bits [1:0] != 2'b11 is illegal):
  - LUI/AUIPC: U-imm, rd.
  - JAL: J-imm, rd.
  - JALR/LOAD/OP-IMM: I-imm, rs1, rd.
  - BRANCH: B-imm, rs1, rs2.
  - STORE: S-imm, rs1, rs2.
  - OP: imm 0, rs1, rs2, rd.
  - MISC-MEM/SYSTEM: no registers, imm 0, rd_wen 0.
  - Any other opcode: o_ex_illegal=1, no registers, rd_wen 0.
- All immediates are sign-extended from instr[31]; U-imm = {instr[31:12], 12'b0}.
- rd_wen = writes-rd && rd != 0. A source is "used" only if its field is used by the opcode and is nonzero.
- stall = i_if_valid && any of:
  - a used rs has its hazard bit set;
  - rd_wen && i_rd_busy (WAW);
  - o_ex_valid && o_ex_rd_wen && o_ex_rd_addr equals a used rs or the new rd (covers the unclaimed held instruction).
- o_if_ready = !i_flush && !stall && (!o_ex_valid || i_ex_ready).
- Accept = i_if_valid && o_if_ready. On accept, register pc, rs data, imm, decode fields and set o_ex_valid. Unused rs data is registered as 0.
- Handoff = o_ex_valid && i_ex_ready && !i_flush. o_ex_valid clears unless a new accept occurs.
- Claim: o_rd_hdvalid = handoff && o_ex_rd_wen; o_rd_hdaddr = o_ex_rd_addr, combinational.
- i_flush: o_ex_valid=0 at the next edge, no claim, no accept. Payload registers may keep stale values.
- Payload holds stable while o_ex_valid && !i_ex_ready.

## Timing
- Reset (async assert, sync-to-clk deassert by integration): o_ex_valid=0; all o_ex_* payload 0; o_rd_hdvalid=0.
- Out of reset, o_if_ready follows its combinational rule.
- Latency: accept at edge N gives o_ex_valid from N+1. Throughput is 1 instruction/cycle with no hazards.
- The claim at handoff edge N is visible as a hazard bit from N+1. The held-instruction compare covers cycle N, so no window exists.
- A writeback release in cycle N clears the hazard at N+1. A dependent instruction stalls through N and is accepted at N+1 at the earliest. No bypass is provided.
- Simultaneous handoff and accept is legal in the same cycle.
- Flush has priority over i_ex_ready and i_if_valid.

## Test plan
- Reset mid-stream with o_ex_valid=1 -> o_ex_valid, o_ex_imm, o_rd_hdvalid all 0 immediately (async); o_if_ready=1 after deassert with no hazards.
- 0x00500093 (addi x1,x0,5) at pc 0x100, i_ex_ready=1 -> next cycle o_ex_valid=1, o_ex_imm=5, o_ex_rd_addr=1, o_ex_rd_wen=1, o_ex_rs1_data=0; o_rd_hdvalid=1 with addr 1 that cycle.
- addi above followed by 0x00108133 (add x2,x1,x1) -> o_if_ready=0 while x1 is held, then while i_rs1_hazard=1. Drop the hazard at cycle K -> accepted at K, o_ex_valid at K+1.
- i_ex_ready=0 for 3 cycles with a second instruction valid -> payload constant, o_if_ready=0, no claim. Ready returns -> one claim, then the next instruction issues the following cycle.
- i_flush with o_ex_valid=1 and i_ex_ready=1 -> o_rd_hdvalid=0, o_if_ready=0, o_ex_valid=0 next cycle.
- 0xFE000EE3 (beq x0,x0,-4) -> o_ex_imm=0xFFFFFFFC, rd_wen 0. 0xFFFFFFFF and 0x00000000 -> o_ex_illegal=1, rd_wen 0, no claim.
